// File: rtl/dec_3to8_seq.sv
// dec_3to8_seq: sequential 3-to-8 decoder with a valid/ready input and a
// timed one-hot output. Each accepted code drives its line for HOLD_CYCLES
// cycles, followed by GAP_CYCLES blank cycles and one mandatory IDLE cycle.
// Build option: define DEC_3TO8_ACTIVE_LOW_EN for an active-low y
// (selected line 0, blank 8'hFF); otherwise y is active-high (blank 8'h00).
module dec_3to8_seq #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [2:0] code,
  input  logic       code_valid,
  output logic       code_ready,
  output logic [7:0] y,
  output logic       y_valid,
  output logic       busy,
  output logic [7:0] dec_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

`ifdef DEC_3TO8_ACTIVE_LOW_EN
  localparam logic [7:0] BLANK = 8'hFF;
`else
  localparam logic [7:0] BLANK = 8'h00;
`endif

  // Counter reload values; the gap reload is unused when there is no gap.
  localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);
  localparam bit          HAS_GAP   = (GAP_CYCLES != 0);
  localparam logic [15:0] GAP_LOAD  = HAS_GAP ? 16'(GAP_CYCLES - 1) : 16'd0;

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [7:0]  y_nxt;
  logic        y_valid_nxt;
  logic        busy_nxt;
  logic [7:0]  dec_cnt_nxt;

  // Map a binary code onto the output line pattern for the selected polarity.
  function automatic logic [7:0] drive_line(input logic [2:0] c);
    logic [7:0] onehot;
    onehot = 8'd1 << c;
`ifdef DEC_3TO8_ACTIVE_LOW_EN
    return ~onehot;
`else
    return onehot;
`endif
  endfunction

  assign code_ready = !rst && enable && (state == IDLE);

  // Next-state, counter and registered-output logic; enable low overrides the FSM.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    y_nxt       = y;
    y_valid_nxt = y_valid;
    busy_nxt    = busy;
    dec_cnt_nxt = dec_cnt;
    if (!enable) begin
      state_nxt   = IDLE;
      y_nxt       = BLANK;
      y_valid_nxt = 1'b0;
      busy_nxt    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          y_nxt       = BLANK;
          y_valid_nxt = 1'b0;
          busy_nxt    = 1'b0;
          if (code_valid) begin
            state_nxt   = HOLD;
            cnt_nxt     = HOLD_LOAD;
            y_nxt       = drive_line(code);
            y_valid_nxt = 1'b1;
            busy_nxt    = 1'b1;
            dec_cnt_nxt = dec_cnt + 8'd1;
          end
        end
        HOLD: begin
          if (cnt == 16'd0) begin
            y_nxt       = BLANK;
            y_valid_nxt = 1'b0;
            if (HAS_GAP) begin
              state_nxt = GAP;
              cnt_nxt   = GAP_LOAD;
              busy_nxt  = 1'b1;
            end else begin
              state_nxt = IDLE;
              busy_nxt  = 1'b0;
            end
          end else begin
            cnt_nxt = cnt - 16'd1;
          end
        end
        GAP: begin
          if (cnt == 16'd0) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
          end else begin
            cnt_nxt = cnt - 16'd1;
          end
        end
        default: begin
          state_nxt   = IDLE;
          y_nxt       = BLANK;
          y_valid_nxt = 1'b0;
          busy_nxt    = 1'b0;
        end
      endcase
    end
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 16'd0;
      y       <= BLANK;
      y_valid <= 1'b0;
      busy    <= 1'b0;
      dec_cnt <= 8'd0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      y       <= y_nxt;
      y_valid <= y_valid_nxt;
      busy    <= busy_nxt;
      dec_cnt <= dec_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_dec_3to8_seq.sv
// Directed bench for dec_3to8_seq: instance a uses the defaults (hold 4,
// gap 1), instance b uses hold 1 with no gap.
module tb_dec_3to8_seq;

`ifdef DEC_3TO8_ACTIVE_LOW_EN
  localparam logic [7:0] BLANK_EXP = 8'hFF;
  localparam logic [7:0] LINE2_EXP = 8'hFB;
  localparam logic [7:0] LINE5_EXP = 8'hDF;
  localparam logic [7:0] LINE6_EXP = 8'hBF;
  localparam logic [7:0] LINE2_B   = 8'hFB;
`else
  localparam logic [7:0] BLANK_EXP = 8'h00;
  localparam logic [7:0] LINE2_EXP = 8'h04;
  localparam logic [7:0] LINE5_EXP = 8'h20;
  localparam logic [7:0] LINE6_EXP = 8'h40;
  localparam logic [7:0] LINE2_B   = 8'h04;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       enable_a, enable_b;
  logic [2:0] code_a, code_b;
  logic       code_valid_a, code_valid_b;
  logic       code_ready_a, code_ready_b;
  logic [7:0] y_a, y_b;
  logic       y_valid_a, y_valid_b;
  logic       busy_a, busy_b;
  logic [7:0] dec_cnt_a, dec_cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] sweep_tab [8];

  always #5 clk = ~clk;

  dec_3to8_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .enable(enable_a), .code(code_a),
    .code_valid(code_valid_a), .code_ready(code_ready_a), .y(y_a),
    .y_valid(y_valid_a), .busy(busy_a), .dec_cnt(dec_cnt_a)
  );

  dec_3to8_seq #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .enable(enable_b), .code(code_b),
    .code_valid(code_valid_b), .code_ready(code_ready_b), .y(y_b),
    .y_valid(y_valid_b), .busy(busy_b), .dec_cnt(dec_cnt_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; enable_a = 1'b1; enable_b = 1'b1;
    code_a = 3'd0; code_b = 3'd0; code_valid_a = 1'b1; code_valid_b = 1'b1;
    tick();
    tick();
    n_tests++; if (code_ready_a !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", code_ready_a); end
    n_tests++; if (y_a !== BLANK_EXP) begin n_fail++; $display("FAIL reset_y got %h want %h", y_a, BLANK_EXP); end
    n_tests++; if (dec_cnt_a !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", dec_cnt_a); end
    n_tests++; if (y_valid_a !== 1'b0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_flags got v=%b b=%b want 0 0", y_valid_a, busy_a); end
    n_tests++; if (code_ready_b !== 1'b0 || y_b !== BLANK_EXP) begin n_fail++; $display("FAIL reset_b got rdy=%b y=%h want 0 %h", code_ready_b, y_b, BLANK_EXP); end
    code_valid_a = 1'b0; code_valid_b = 1'b0;
    rst = 1'b0;
    #1;
    n_tests++; if (code_ready_a !== 1'b1) begin n_fail++; $display("FAIL release_ready got %b want 1", code_ready_a); end
  endtask

  task automatic test_sweep;
    code_valid_a = 1'b1;
    for (int k = 0; k < 8; k++) begin
      code_a = 3'(k);
      #1;
      n_tests++; if (code_ready_a !== 1'b1) begin n_fail++; $display("FAIL sweep_ready code %0d got %b want 1", k, code_ready_a); end
      tick();
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (y_a !== sweep_tab[k] || y_valid_a !== 1'b1 || busy_a !== 1'b1 || code_ready_a !== 1'b0) begin
          n_fail++;
          $display("FAIL sweep_hold code %0d cyc %0d got y=%h v=%b b=%b r=%b want y=%h v=1 b=1 r=0",
                   k, i, y_a, y_valid_a, busy_a, code_ready_a, sweep_tab[k]);
        end
        code_a = ~3'(k);
        tick();
      end
      n_tests++;
      if (y_a !== BLANK_EXP || y_valid_a !== 1'b0 || busy_a !== 1'b1 || code_ready_a !== 1'b0) begin
        n_fail++;
        $display("FAIL sweep_gap code %0d got y=%h v=%b b=%b r=%b want y=%h v=0 b=1 r=0",
                 k, y_a, y_valid_a, busy_a, code_ready_a, BLANK_EXP);
      end
      tick();
      n_tests++;
      if (busy_a !== 1'b0 || y_a !== BLANK_EXP) begin
        n_fail++;
        $display("FAIL sweep_idle code %0d got y=%h b=%b want y=%h b=0", k, y_a, busy_a, BLANK_EXP);
      end
    end
    code_valid_a = 1'b0;
    n_tests++; if (dec_cnt_a !== 8'd8) begin n_fail++; $display("FAIL sweep_count got %0d want 8", dec_cnt_a); end
  endtask

  task automatic test_no_gap;
    code_b = 3'd5; code_valid_b = 1'b1;
    #1;
    n_tests++; if (code_ready_b !== 1'b1) begin n_fail++; $display("FAIL nogap_ready0 got %b want 1", code_ready_b); end
    tick();
    n_tests++;
    if (y_b !== LINE5_EXP || y_valid_b !== 1'b1 || code_ready_b !== 1'b0) begin
      n_fail++;
      $display("FAIL nogap_hold got y=%h v=%b r=%b want y=%h v=1 r=0", y_b, y_valid_b, code_ready_b, LINE5_EXP);
    end
    tick();
    n_tests++;
    if (y_valid_b !== 1'b0 || y_b !== BLANK_EXP || code_ready_b !== 1'b1 || busy_b !== 1'b0) begin
      n_fail++;
      $display("FAIL nogap_after got y=%h v=%b r=%b b=%b want y=%h v=0 r=1 b=0", y_b, y_valid_b, code_ready_b, busy_b, BLANK_EXP);
    end
    code_b = 3'd2;
    tick();
    n_tests++; if (y_b !== LINE2_B || y_valid_b !== 1'b1) begin n_fail++; $display("FAIL nogap_second got y=%h v=%b want y=%h v=1", y_b, y_valid_b, LINE2_B); end
    code_valid_b = 1'b0;
    tick();
    n_tests++; if (dec_cnt_b !== 8'd2) begin n_fail++; $display("FAIL nogap_count got %0d want 2", dec_cnt_b); end
  endtask

  task automatic test_abort;
    do_reset();
    code_a = 3'd3; code_valid_a = 1'b1;
    tick();
    code_valid_a = 1'b0;
    tick();
    enable_a = 1'b0;
    #1;
    n_tests++; if (code_ready_a !== 1'b0) begin n_fail++; $display("FAIL abort_ready_low got %b want 0", code_ready_a); end
    tick();
    n_tests++;
    if (y_a !== BLANK_EXP || busy_a !== 1'b0 || y_valid_a !== 1'b0 || dec_cnt_a !== 8'd1) begin
      n_fail++;
      $display("FAIL abort_state got y=%h b=%b v=%b cnt=%0d want y=%h b=0 v=0 cnt=1", y_a, busy_a, y_valid_a, dec_cnt_a, BLANK_EXP);
    end
    enable_a = 1'b1;
    #1;
    n_tests++; if (code_ready_a !== 1'b1) begin n_fail++; $display("FAIL abort_ready_back got %b want 1", code_ready_a); end
    code_a = 3'd6; code_valid_a = 1'b1;
    tick();
    code_valid_a = 1'b0;
    n_tests++; if (y_a !== LINE6_EXP || dec_cnt_a !== 8'd2) begin n_fail++; $display("FAIL abort_reaccept got y=%h cnt=%0d want y=%h cnt=2", y_a, dec_cnt_a, LINE6_EXP); end
  endtask

  task automatic test_wrap;
    do_reset();
    code_valid_b = 1'b1;
    for (int i = 0; i < 256; i++) begin
      code_b = 3'(i);
      tick();
      tick();
      if (i == 254) begin
        n_tests++; if (dec_cnt_b !== 8'd255) begin n_fail++; $display("FAIL wrap_255 got %0d want 255", dec_cnt_b); end
      end
    end
    n_tests++; if (dec_cnt_b !== 8'd0) begin n_fail++; $display("FAIL wrap_256 got %0d want 0", dec_cnt_b); end
    tick();
    code_valid_b = 1'b0;
    n_tests++; if (dec_cnt_b !== 8'd1) begin n_fail++; $display("FAIL wrap_257 got %0d want 1", dec_cnt_b); end
  endtask

  task automatic test_polarity;
    int waited = 0;
    while (code_ready_a !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    n_tests++; if (code_ready_a !== 1'b1) begin n_fail++; $display("FAIL pol_wait_ready got %b want 1 within 20 cycles", code_ready_a); end
    code_a = 3'd2; code_valid_a = 1'b1;
    tick();
    code_valid_a = 1'b0;
    n_tests++; if (y_a !== LINE2_EXP) begin n_fail++; $display("FAIL pol_hold got %h want %h", y_a, LINE2_EXP); end
    tick(); tick(); tick();
    n_tests++; if (y_a !== LINE2_EXP || y_valid_a !== 1'b1) begin n_fail++; $display("FAIL pol_hold_last got y=%h v=%b want %h 1", y_a, y_valid_a, LINE2_EXP); end
    tick();
    n_tests++; if (y_a !== BLANK_EXP || busy_a !== 1'b1) begin n_fail++; $display("FAIL pol_gap got y=%h b=%b want %h 1", y_a, busy_a, BLANK_EXP); end
    tick();
    n_tests++; if (y_a !== BLANK_EXP || code_ready_a !== 1'b1) begin n_fail++; $display("FAIL pol_idle got y=%h r=%b want %h 1", y_a, code_ready_a, BLANK_EXP); end
  endtask

  initial begin
`ifdef DEC_3TO8_ACTIVE_LOW_EN
    sweep_tab = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
`else
    sweep_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
`endif
    test_reset();
    test_sweep();
    test_no_gap();
    test_abort();
    test_wrap();
    test_polarity();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
